// File: rtl/vga_frame_scan.sv
// vga_frame_scan: VGA raster timing generator with an image-window read strobe.
// The counter, sync and strobe outputs are all registered. Each one is decoded
// from the next counter value, so it lines up with the xpos/ypos of the same
// cycle.
module vga_frame_scan #(
  parameter int               H_ACTIVE      = 640,
  parameter int               H_FP          = 16,
  parameter int               H_SYNC        = 96,
  parameter int               H_BP          = 48,
  parameter int               V_ACTIVE      = 480,
  parameter int               V_FP          = 10,
  parameter int               V_SYNC        = 2,
  parameter int               V_BP          = 33,
  parameter logic [7:0]       DISPLAY_STATE = 8'h03
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  W,
  input  logic [7:0]  H,
  input  logic [9:0]  STARTCOL,
  input  logic [9:0]  STARTROW,
  input  logic [7:0]  state,
  output logic        spram_rd_sig,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        VGA_HS,
  output logic        VGA_VS
);

  // Raster landmarks, pre-sized to the counter width.
  localparam logic [11:0] H_LAST   = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] V_LAST   = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] HS_FIRST = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_LAST  = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [11:0] VS_FIRST = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_LAST  = 12'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Window membership: start <= pos < start+len. The sum is formed at 11 bits,
  // so a window that runs past 1023 never wraps back onto low positions.
  // A zero length gives an empty window.
  function automatic logic in_span(input logic [11:0] pos,
                                   input logic [9:0]  start,
                                   input logic [7:0]  len);
    logic [10:0] lo;
    logic [10:0] hi;
    lo = {1'b0, start};
    hi = lo + {3'b000, len};
    return (pos >= {1'b0, lo}) && (pos < {1'b0, hi});
  endfunction

  // Inclusive range test used for the sync pulses.
  function automatic logic in_range(input logic [11:0] pos,
                                    input logic [11:0] first,
                                    input logic [11:0] last);
    return (pos >= first) && (pos <= last);
  endfunction

  logic [11:0] x_nxt_p0;
  logic [11:0] y_nxt_p0;
  logic        hs_nxt_p0;
  logic        vs_nxt_p0;
  logic        rd_nxt_p0;

  // Next raster position: x wraps at the line end and carries into y.
  always_comb begin
    x_nxt_p0 = xpos + 12'd1;
    y_nxt_p0 = ypos;
    if (xpos == H_LAST) begin
      x_nxt_p0 = 12'd0;
      if (ypos == V_LAST) begin
        y_nxt_p0 = 12'd0;
      end else begin
        y_nxt_p0 = ypos + 12'd1;
      end
    end
  end

  // Decode syncs and the read strobe from the next position.
  // The strobe uses the live window and state inputs. The state test sits in
  // an if, so an unknown state code takes the no-read path.
  always_comb begin
    hs_nxt_p0 = ~in_range(x_nxt_p0, HS_FIRST, HS_LAST);
    vs_nxt_p0 = ~in_range(y_nxt_p0, VS_FIRST, VS_LAST);
    rd_nxt_p0 = 1'b0;
    if (state == DISPLAY_STATE) begin
      if ((x_nxt_p0 < H_ACT) && (y_nxt_p0 < V_ACT) &&
          in_span(x_nxt_p0, STARTCOL, W) && in_span(y_nxt_p0, STARTROW, H)) begin
        rd_nxt_p0 = 1'b1;
      end
    end
  end

  // ---- stage p0 -> outputs: register position, syncs and strobe together ----
  // Register the raster state. Reset is asynchronous and returns the raster to
  // the origin with both syncs idle (high).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xpos         <= 12'd0;
      ypos         <= 12'd0;
      VGA_HS       <= 1'b1;
      VGA_VS       <= 1'b1;
      spram_rd_sig <= 1'b0;
    end else begin
      xpos         <= x_nxt_p0;
      ypos         <= y_nxt_p0;
      VGA_HS       <= hs_nxt_p0;
      VGA_VS       <= vs_nxt_p0;
      spram_rd_sig <= rd_nxt_p0;
    end
  end

endmodule

// File: tb/tb_vga_frame_scan.sv
// tb_vga_frame_scan: directed bench for vga_frame_scan on a reduced raster
// (80 x 30 total, 64 x 24 active). This keeps several whole frames short.
// The raster landmarks keep the same ordering and meaning as the full-size
// 640x480 timing.
module tb_vga_frame_scan;

  localparam int HA = 64, HF = 4, HSY = 8, HB = 4;
  localparam int VA = 24, VF = 2, VSY = 2, VB = 2;
  localparam int HT = HA + HF + HSY + HB;   // 80
  localparam int VT = VA + VF + VSY + VB;   // 30
  localparam int FRAME = HT * VT;           // 2400

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  W, H, state;
  logic [9:0]  STARTCOL, STARTROW;
  logic        spram_rd_sig, VGA_HS, VGA_VS;
  logic [11:0] xpos, ypos;

  int errors = 0;
  int checks = 0;

  vga_frame_scan #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .DISPLAY_STATE(8'h03)
  ) dut (
    .clk(clk), .rst(rst), .W(W), .H(H), .STARTCOL(STARTCOL), .STARTROW(STARTROW),
    .state(state), .spram_rd_sig(spram_rd_sig), .xpos(xpos), .ypos(ypos),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS)
  );

  always #5 clk = ~clk;

  typedef struct {
    int w, h, sc, sr, st;
    int exp_cnt;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_xy(input int x, input int y);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < FRAME + 10; n++) begin
      @(negedge clk);
      if (xpos == 12'(x) && ypos == 12'(y)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_xy(%0d,%0d): timeout, position never reached", x, y);
    end
  endtask

  function automatic bit exp_rd(input int x, input int y, input vec_t v);
    return (v.st == 3) && (x >= v.sc) && (x < v.sc + v.w) &&
           (y >= v.sr) && (y < v.sr + v.h) && (x < HA) && (y < VA);
  endfunction

  task automatic apply(input vec_t v);
    W = 8'(v.w); H = 8'(v.h); STARTCOL = 10'(v.sc); STARTROW = 10'(v.sr);
    state = 8'(v.st);
  endtask

  initial begin
    int cnt, bad, hs_low, vs_low, hs_first, hs_run, hs_max, cnt_bad, hs_bad, vs_bad;
    int ex, ey;
    int lc[VT];
    vec_t v;

    vecs[0] = '{w:5,   h:4,   sc:20, sr:20, st:3,    exp_cnt:20};
    vecs[1] = '{w:5,   h:4,   sc:20, sr:20, st:0,    exp_cnt:0};
    vecs[2] = '{w:5,   h:4,   sc:62, sr:22, st:3,    exp_cnt:4};
    vecs[3] = '{w:0,   h:4,   sc:20, sr:20, st:3,    exp_cnt:0};
    vecs[4] = '{w:5,   h:0,   sc:20, sr:20, st:3,    exp_cnt:0};
    vecs[5] = '{w:255, h:255, sc:0,  sr:0,  st:3,    exp_cnt:1536};
    vecs[6] = '{w:5,   h:4,   sc:20, sr:20, st:8'h83, exp_cnt:0};
    vecs[7] = '{w:5,   h:4,   sc:20, sr:20, st:2,    exp_cnt:0};
    vecs[8] = '{w:3,   h:2,   sc:0,  sr:0,  st:3,    exp_cnt:6};
    vecs[9] = '{w:10,  h:10,  sc:60, sr:20, st:3,    exp_cnt:16};

    // Reset values
    rst = 1'b1; W = 8'd0; H = 8'd0; STARTCOL = 10'd0; STARTROW = 10'd0; state = 8'd0;
    repeat (3) @(negedge clk);
    check("reset xpos", int'(xpos), 0);
    check("reset ypos", int'(ypos), 0);
    check("reset HS", int'(VGA_HS), 1);
    check("reset VS", int'(VGA_VS), 1);
    check("reset rd", int'(spram_rd_sig), 0);
    rst = 1'b0;
    @(negedge clk);
    check("first edge xpos", int'(xpos), 1);
    check("first edge ypos", int'(ypos), 0);

    // Free-running timing over two frames
    wait_xy(0, 0);
    ex = 0; ey = 0; cnt_bad = 0; hs_bad = 0; vs_bad = 0;
    hs_low = 0; vs_low = 0; hs_first = -1; hs_run = 0; hs_max = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (int'(xpos) != ex || int'(ypos) != ey) cnt_bad++;
      if (VGA_HS !== !(ex >= HA + HF && ex < HA + HF + HSY)) hs_bad++;
      if (VGA_VS !== !(ey >= VA + VF && ey < VA + VF + VSY)) vs_bad++;
      if (!VGA_HS) begin
        hs_low++; hs_run++;
        if (hs_first < 0) hs_first = int'(xpos);
        if (hs_run > hs_max) hs_max = hs_run;
      end else begin
        hs_run = 0;
      end
      if (!VGA_VS) vs_low++;
      ex = ex + 1;
      if (ex == HT) begin
        ex = 0;
        ey = (ey == VT - 1) ? 0 : ey + 1;
      end
      @(negedge clk);
    end
    check("counter sequence errors", cnt_bad, 0);
    check("HS decode errors", hs_bad, 0);
    check("VS decode errors", vs_bad, 0);
    check("HS first low xpos", hs_first, HA + HF);
    check("HS pulse width", hs_max, HSY);
    check("HS low cycles 2 frames", hs_low, 2 * VT * HSY);
    check("VS low cycles 2 frames", vs_low, 2 * VSY * HT);
    check("frame period wrap x", int'(xpos), 0);
    check("frame period wrap y", int'(ypos), 0);

    // Table-driven window vectors, one full frame each
    for (int k = 0; k < 10; k++) begin
      v = vecs[k];
      apply(v);
      wait_xy(0, 0);
      cnt = 0; bad = 0;
      for (int i = 0; i < FRAME; i++) begin
        if (spram_rd_sig) cnt++;
        if (spram_rd_sig !== exp_rd(int'(xpos), int'(ypos), v)) bad++;
        @(negedge clk);
      end
      check($sformatf("vec%0d strobe count", k), cnt, v.exp_cnt);
      check($sformatf("vec%0d strobe placement errors", k), bad, 0);
    end

    // State switched to display mid-frame at line 21
    v = vecs[1];
    apply(v);
    wait_xy(0, 0);
    foreach (lc[i]) lc[i] = 0;
    cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (spram_rd_sig) begin
        cnt++;
        lc[ypos] = lc[ypos] + 1;
      end
      if (xpos == 12'd40 && ypos == 12'd21) state = 8'h03;
      @(negedge clk);
    end
    check("switch frame total", cnt, 10);
    check("switch frame lines 20-21", lc[20] + lc[21], 0);
    check("switch frame line 22", lc[22], 5);
    check("switch frame line 23", lc[23], 5);
    v = vecs[0];
    cnt = 0; bad = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (spram_rd_sig) cnt++;
      if (spram_rd_sig !== exp_rd(int'(xpos), int'(ypos), v)) bad++;
      @(negedge clk);
    end
    check("frame after switch total", cnt, 20);
    check("frame after switch placement errors", bad, 0);

    // Asynchronous reset while the strobe is high
    wait_xy(22, 21);
    check("pre-reset rd high", int'(spram_rd_sig), 1);
    rst = 1'b1;
    #1;
    check("async reset xpos", int'(xpos), 0);
    check("async reset ypos", int'(ypos), 0);
    check("async reset rd", int'(spram_rd_sig), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("restart xpos", int'(xpos), 1);
    check("restart ypos", int'(ypos), 0);

    // Asynchronous reset while both syncs are low
    wait_xy(70, 26);
    check("pre-reset HS low", int'(VGA_HS), 0);
    check("pre-reset VS low", int'(VGA_VS), 0);
    rst = 1'b1;
    #1;
    check("async reset HS", int'(VGA_HS), 1);
    check("async reset VS", int'(VGA_VS), 1);
    check("async reset2 xpos", int'(xpos), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("count after restart xpos", int'(xpos), 6);
    check("count after restart ypos", int'(ypos), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
